// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for a multi-cycle ALU datapath: operand loads, execute, writeback, completion.
// Optional macro ALU_STATUS_EN enables the zero-flag status register and compare (no-writeback) instructions.
module alu_seq_ctrl #(
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        ins_op,
  input  logic              ins_cmp,
  input  logic [REG_AW-1:0] ins_rd,
  input  logic [REG_AW-1:0] ins_rn,
  input  logic [REG_AW-1:0] ins_rm,
  input  logic              Z,
  output logic [REG_AW-1:0] r_addr,
  output logic [REG_AW-1:0] w_addr,
  output logic              en_A,
  output logic              en_B,
  output logic              en_C,
  output logic              w_en,
  output logic              en_status,
  output logic [1:0]        ALU_op,
  output logic              waiting,
  output logic              done,
  output logic              status_Z,
  output logic [7:0]        ins_count
);

  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = 8;
  localparam logic [OP_W-1:0] OP_NOTB = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                cmp_q, cmp_d;
  logic [REG_AW-1:0]   rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                status_z_q, status_z_d;

  logic [REG_AW-1:0]   r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic                en_a_q, en_a_d, en_b_q, en_b_d, en_c_q, en_c_d, w_en_q, w_en_d;
  logic                en_status_q, en_status_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic                waiting_q, waiting_d, done_q, done_d;

`ifdef ALU_STATUS_EN
  logic cmp_in_c;
  assign cmp_in_c = ins_cmp;
`else
  // Without the status register a compare is meaningless; every instruction writes back.
  logic cmp_in_c;
  logic unused_cfg_c;
  assign cmp_in_c     = 1'b0;
  assign unused_cfg_c = ^{ins_cmp, Z};
`endif

  // Next state, latched fields and registered Moore outputs decoded from the next state.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cmp_d       = cmp_q;
    rd_d        = rd_q;
    rn_d        = rn_q;
    rm_d        = rm_q;
    count_d     = count_q;
    status_z_d  = status_z_q;
    r_addr_d    = '0;
    w_addr_d    = '0;
    en_a_d      = 1'b0;
    en_b_d      = 1'b0;
    en_c_d      = 1'b0;
    w_en_d      = 1'b0;
    en_status_d = 1'b0;
    alu_op_d    = '0;
    waiting_d   = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = ins_op;
          cmp_d   = cmp_in_c;
          rd_d    = ins_rd;
          rn_d    = ins_rn;
          rm_d    = ins_rm;
          state_d = (ins_op == OP_NOTB) ? S_LOAD_B : S_LOAD_A;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_EXEC;
      S_EXEC: begin
        state_d = cmp_q ? S_DONE : S_WRITE;
`ifdef ALU_STATUS_EN
        status_z_d = Z;
`endif
      end
      S_WRITE: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        count_d = count_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_IDLE:   waiting_d = 1'b1;
      S_LOAD_A: begin
        r_addr_d = rn_d;
        en_a_d   = 1'b1;
      end
      S_LOAD_B: begin
        r_addr_d = rm_d;
        en_b_d   = 1'b1;
      end
      S_EXEC: begin
        alu_op_d = op_d;
        en_c_d   = ~cmp_d;
`ifdef ALU_STATUS_EN
        en_status_d = 1'b1;
`endif
      end
      S_WRITE: begin
        w_addr_d = rd_d;
        w_en_d   = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: waiting_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cmp_q       <= 1'b0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      count_q     <= '0;
      status_z_q  <= 1'b0;
      r_addr_q    <= '0;
      w_addr_q    <= '0;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      en_c_q      <= 1'b0;
      w_en_q      <= 1'b0;
      en_status_q <= 1'b0;
      alu_op_q    <= '0;
      waiting_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cmp_q       <= cmp_d;
      rd_q        <= rd_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      count_q     <= count_d;
      status_z_q  <= status_z_d;
      r_addr_q    <= r_addr_d;
      w_addr_q    <= w_addr_d;
      en_a_q      <= en_a_d;
      en_b_q      <= en_b_d;
      en_c_q      <= en_c_d;
      w_en_q      <= w_en_d;
      en_status_q <= en_status_d;
      alu_op_q    <= alu_op_d;
      waiting_q   <= waiting_d;
      done_q      <= done_d;
    end
  end

  assign r_addr    = r_addr_q;
  assign w_addr    = w_addr_q;
  assign en_A      = en_a_q;
  assign en_B      = en_b_q;
  assign en_C      = en_c_q;
  assign w_en      = w_en_q;
  assign ALU_op    = alu_op_q;
  assign waiting   = waiting_q;
  assign done      = done_q;
  assign ins_count = count_q;
  assign en_status = en_status_q;
  assign status_Z  = status_z_q;

endmodule
